// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter.
//   - Arbiter FSM state encoding (ARB_IDLE / ARB_ISSUE / ARB_WAIT)
//   - Requester port identifiers (PORT_PTW = 0, PORT_CC = 1)
//   - Default bus widths
//   - pick_grant(): chooses the next owner from the pending flags
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_LINE_W = 512;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_WAIT  = 2'd2;

   localparam logic PORT_PTW = 1'b0;
   localparam logic PORT_CC  = 1'b1;

   // A lone pending port always wins. On a tie, fixed priority favours the
   // page-table walker; round-robin favours whoever was not served last.
   function automatic logic pick_grant(input logic [1:0] pend,
                                       input logic       last_grant,
                                       input logic       fixed_prio);
      logic g;
      if (pend == 2'b11) begin
         g = fixed_prio ? PORT_PTW : ~last_grant;
      end else if (pend[0]) begin
         g = PORT_PTW;
      end else begin
         g = PORT_CC;
      end
      return g;
   endfunction

endpackage

// File: rtl/mem_arb_req_latch.sv
// Per-requester pending-entry holder for the main-memory arbiter.
// Captures a one-cycle read or write pulse into a single pending slot and
// holds it until the arbiter reports completion.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   addr, wdata              requester address / write data (sampled on pulse)
//   read_req, write_req      requester request pulses
//   clr                      completion of this port's access (from arbiter)
//   pend_valid               slot holds an outstanding request
//   pend_addr, pend_wdata    captured address / write data
//   pend_is_write            captured operation type
//   err                      one-cycle flag: this cycle's pulse was dropped
module mem_arb_req_latch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              read_req,
   input  logic              write_req,
   input  logic              clr,
   output logic              pend_valid,
   output logic [ADDR_W-1:0] pend_addr,
   output logic [DATA_W-1:0] pend_wdata,
   output logic              pend_is_write,
   output logic              err
);

   logic req_any;
   logic req_both;
   logic slot_busy;
   logic accept;

   // The slot frees up on the completion edge, so the owner may re-request
   // in the same cycle its ready is returned.
   assign req_any   = read_req | write_req;
   assign req_both  = read_req & write_req;
   assign slot_busy = pend_valid & ~clr;
   assign accept    = req_any & ~req_both & ~slot_busy;
   assign err       = req_both | (req_any & slot_busy);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
      end else if (accept) begin
         pend_valid <= 1'b1;
      end else if (clr) begin
         pend_valid <= 1'b0;
      end
   end

   // Payload only matters while pend_valid is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         pend_addr     <= addr;
         pend_wdata    <= wdata;
         pend_is_write <= write_req;
      end
   end

endmodule

// File: rtl/main_mem_arbiter.sv
// Two-port arbiter for the single main-memory port.
// Port 0 is the MMU page-table walker (ptw), port 1 the cache controller (cc).
// Each request pulse is latched, one request at a time is granted
// (round-robin or fixed priority), issued to memory for one cycle, and the
// memory ready pulse / read line is steered back to the owner only.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   ptw_* / cc_*                      requester address, wdata, read/write
//                                     pulses in; ready pulse and line out
//   main_mem_addr/data_out/read_req/write_req   memory request (ISSUE only)
//   main_mem_data_in, main_mem_ready  memory response
//   arb_busy                          arbiter is in ISSUE or WAIT
//   arb_owner                         port of current / last grant
//   proto_err                         sticky dropped-request flag
module main_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LINE_W     = DEF_LINE_W,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ptw_addr,
   input  logic [DATA_W-1:0] ptw_wdata,
   input  logic              ptw_read_req,
   input  logic              ptw_write_req,
   output logic              ptw_ready,
   output logic [LINE_W-1:0] ptw_data_in,
   input  logic [ADDR_W-1:0] cc_addr,
   input  logic [DATA_W-1:0] cc_wdata,
   input  logic              cc_read_req,
   input  logic              cc_write_req,
   output logic              cc_ready,
   output logic [LINE_W-1:0] cc_data_in,
   output logic [ADDR_W-1:0] main_mem_addr,
   output logic [DATA_W-1:0] main_mem_data_out,
   output logic              main_mem_read_req,
   output logic              main_mem_write_req,
   input  logic [LINE_W-1:0] main_mem_data_in,
   input  logic              main_mem_ready,
   output logic              arb_busy,
   output logic              arb_owner,
   output logic              proto_err
);

   logic [1:0]        state;
   logic              owner;
   logic              last_grant;
   logic              grant;
   logic              mem_done;
   logic [1:0]        clr;
   logic [1:0]        err;
   logic [1:0]        pend_vld;
   logic [ADDR_W-1:0] pend_addr  [2];
   logic [DATA_W-1:0] pend_wdata [2];
   logic [1:0]        pend_wr;

   mem_arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ptw_latch (
      .clk           (clk),
      .rst_n         (rst_n),
      .addr          (ptw_addr),
      .wdata         (ptw_wdata),
      .read_req      (ptw_read_req),
      .write_req     (ptw_write_req),
      .clr           (clr[0]),
      .pend_valid    (pend_vld[0]),
      .pend_addr     (pend_addr[0]),
      .pend_wdata    (pend_wdata[0]),
      .pend_is_write (pend_wr[0]),
      .err           (err[0])
   );

   mem_arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cc_latch (
      .clk           (clk),
      .rst_n         (rst_n),
      .addr          (cc_addr),
      .wdata         (cc_wdata),
      .read_req      (cc_read_req),
      .write_req     (cc_write_req),
      .clr           (clr[1]),
      .pend_valid    (pend_vld[1]),
      .pend_addr     (pend_addr[1]),
      .pend_wdata    (pend_wdata[1]),
      .pend_is_write (pend_wr[1]),
      .err           (err[1])
   );

   assign grant     = pick_grant(pend_vld, last_grant, FIXED_PRIO != 0);
   // Ready arriving during ISSUE is deliberately not a completion.
   assign mem_done  = (state == ARB_WAIT) && main_mem_ready;
   assign clr[0]    = mem_done && (owner == PORT_PTW);
   assign clr[1]    = mem_done && (owner == PORT_CC);
   assign arb_busy  = (state != ARB_IDLE);
   assign arb_owner = owner;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         owner      <= PORT_PTW;
         last_grant <= PORT_CC;
         proto_err  <= 1'b0;
      end else begin
         proto_err <= proto_err | err[0] | err[1];
         case (state)
            ARB_IDLE: begin
               if (|pend_vld) begin
                  owner <= grant;
                  state <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               state <= ARB_WAIT;
            end
            ARB_WAIT: begin
               if (main_mem_ready) begin
                  last_grant <= owner;
                  state      <= ARB_IDLE;
               end
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      main_mem_addr      = '0;
      main_mem_data_out  = '0;
      main_mem_read_req  = 1'b0;
      main_mem_write_req = 1'b0;
      if (state == ARB_ISSUE) begin
         main_mem_addr      = pend_addr[owner];
         main_mem_data_out  = pend_wdata[owner];
         main_mem_read_req  = ~pend_wr[owner];
         main_mem_write_req = pend_wr[owner];
      end
      ptw_ready   = clr[0];
      cc_ready    = clr[1];
      ptw_data_in = clr[0] ? main_mem_data_in : '0;
      cc_data_in  = clr[1] ? main_mem_data_in : '0;
   end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Bench for main_mem_arbiter: instance 0 is round-robin, instance 1 fixed
// priority. Both share the requester inputs; each has its own memory side.
module tb_main_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LINE_W = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [ADDR_W-1:0] ptw_addr, cc_addr;
   logic [DATA_W-1:0] ptw_wdata, cc_wdata;
   logic              ptw_rd, ptw_wr, cc_rd, cc_wr;

   logic [1:0]        ptw_ready, cc_ready, mm_rd, mm_wr, busy, owner, perr, mem_ready;
   logic [ADDR_W-1:0] mm_addr  [2];
   logic [DATA_W-1:0] mm_wd    [2];
   logic [LINE_W-1:0] ptw_din  [2];
   logic [LINE_W-1:0] cc_din   [2];
   logic [LINE_W-1:0] mem_line [2];

   int checks = 0;
   int errors = 0;
   bit auto_resp = 1'b0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      main_mem_arbiter #(
         .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .FIXED_PRIO(g)
      ) dut (
         .clk                (clk),
         .rst_n              (rst_n),
         .ptw_addr           (ptw_addr),
         .ptw_wdata          (ptw_wdata),
         .ptw_read_req       (ptw_rd),
         .ptw_write_req      (ptw_wr),
         .ptw_ready          (ptw_ready[g]),
         .ptw_data_in        (ptw_din[g]),
         .cc_addr            (cc_addr),
         .cc_wdata           (cc_wdata),
         .cc_read_req        (cc_rd),
         .cc_write_req       (cc_wr),
         .cc_ready           (cc_ready[g]),
         .cc_data_in         (cc_din[g]),
         .main_mem_addr      (mm_addr[g]),
         .main_mem_data_out  (mm_wd[g]),
         .main_mem_read_req  (mm_rd[g]),
         .main_mem_write_req (mm_wr[g]),
         .main_mem_data_in   (mem_line[g]),
         .main_mem_ready     (mem_ready[g]),
         .arb_busy           (busy[g]),
         .arb_owner          (owner[g]),
         .proto_err          (perr[g])
      );
   end

   // Reference model state, per instance [g] and per port [p].
   logic [1:0]        m_pend      [2];
   logic [ADDR_W-1:0] m_addr      [2][2];
   logic [DATA_W-1:0] m_wd        [2][2];
   logic              m_wr        [2][2];
   logic              m_out       [2];
   logic              m_oport     [2];
   logic              m_last      [2];
   logic              m_owner     [2];
   logic              m_perr      [2];
   logic              m_prev_idle [2];
   logic [1:0]        m_pend_prev [2];

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ptw_rd = 0; ptw_wr = 0; cc_rd = 0; cc_wr = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      mem_ready = 2'b00;
      step();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Cycle-level rule checker running beside every test.
   task automatic monitor();
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            logic       exp_issue;
            logic       w;
            logic [1:0] rdy;
            logic [1:0] cur;
            logic [1:0] prd, pwr;
            if (!rst_n) begin
               checks++;
               if ({ptw_ready[g], cc_ready[g], mm_rd[g], mm_wr[g], busy[g], owner[g], perr[g]} !== 7'b0 ||
                   mm_addr[g] !== '0 || mm_wd[g] !== '0 || ptw_din[g] !== '0 || cc_din[g] !== '0) begin
                  errors++;
                  $display("FAIL mon_reset[%0d]: rdy=%b%b req=%b%b busy=%b owner=%b perr=%b, required all zero",
                           g, ptw_ready[g], cc_ready[g], mm_rd[g], mm_wr[g], busy[g], owner[g], perr[g]);
               end
               m_pend[g] = 2'b00; m_out[g] = 0; m_oport[g] = 0; m_last[g] = 1;
               m_owner[g] = 0; m_perr[g] = 0; m_prev_idle[g] = 1; m_pend_prev[g] = 2'b00;
            end else begin
               exp_issue = !m_out[g] && m_prev_idle[g] && (m_pend_prev[g] != 2'b00);
               if (m_pend_prev[g] == 2'b11) w = (g == 1) ? 1'b0 : ~m_last[g];
               else                         w = m_pend_prev[g][0] ? 1'b0 : 1'b1;
               checks++;
               if (exp_issue) begin
                  if (mm_rd[g] !== ~m_wr[g][w] || mm_wr[g] !== m_wr[g][w] || mm_addr[g] !== m_addr[g][w] ||
                      mm_wd[g] !== m_wd[g][w] || owner[g] !== w) begin
                     errors++;
                     $display("FAIL mon_issue[%0d]: rd=%b wr=%b addr=%h wd=%h owner=%b, required rd=%b wr=%b addr=%h wd=%h owner=%b",
                              g, mm_rd[g], mm_wr[g], mm_addr[g], mm_wd[g], owner[g],
                              ~m_wr[g][w], m_wr[g][w], m_addr[g][w], m_wd[g][w], w);
                  end
               end else if (mm_rd[g] !== 1'b0 || mm_wr[g] !== 1'b0 || mm_addr[g] !== '0 || mm_wd[g] !== '0) begin
                  errors++;
                  $display("FAIL mon_bus_quiet[%0d]: rd=%b wr=%b addr=%h wd=%h, required all 0",
                           g, mm_rd[g], mm_wr[g], mm_addr[g], mm_wd[g]);
               end
               rdy = 2'b00;
               if (m_out[g] && mem_ready[g]) rdy[m_oport[g]] = 1'b1;
               checks++;
               if (ptw_ready[g] !== rdy[0] || cc_ready[g] !== rdy[1] ||
                   ptw_din[g] !== (rdy[0] ? mem_line[g] : {LINE_W{1'b0}}) ||
                   cc_din[g] !== (rdy[1] ? mem_line[g] : {LINE_W{1'b0}})) begin
                  errors++;
                  $display("FAIL mon_ready[%0d]: ptw_ready=%b cc_ready=%b ptw_din[31:0]=%h cc_din[31:0]=%h, required ready=%b%b line[31:0]=%h",
                           g, ptw_ready[g], cc_ready[g], ptw_din[g][31:0], cc_din[g][31:0],
                           rdy[0], rdy[1], mem_line[g][31:0]);
               end
               checks++;
               if (busy[g] !== (exp_issue | m_out[g]) || (!exp_issue && owner[g] !== m_owner[g])) begin
                  errors++;
                  $display("FAIL mon_status[%0d]: busy=%b owner=%b, required busy=%b owner=%b",
                           g, busy[g], owner[g], exp_issue | m_out[g], exp_issue ? w : m_owner[g]);
               end
               checks++;
               if (perr[g] !== m_perr[g]) begin
                  errors++;
                  $display("FAIL mon_proto_err[%0d]: got %b, required %b", g, perr[g], m_perr[g]);
               end
               // advance the model past this clock edge
               cur = m_pend[g];
               prd = {cc_rd, ptw_rd};
               pwr = {cc_wr, ptw_wr};
               for (int p = 0; p < 2; p++) begin
                  if (rdy[p]) m_pend[g][p] = 1'b0;
                  if (prd[p] | pwr[p]) begin
                     if ((prd[p] & pwr[p]) || m_pend[g][p]) begin
                        m_perr[g] = 1'b1;
                     end else begin
                        m_pend[g][p] = 1'b1;
                        m_addr[g][p] = (p == 0) ? ptw_addr : cc_addr;
                        m_wd[g][p]   = (p == 0) ? ptw_wdata : cc_wdata;
                        m_wr[g][p]   = pwr[p];
                     end
                  end
               end
               m_prev_idle[g] = !m_out[g] && !exp_issue;
               if (exp_issue) begin
                  m_out[g] = 1'b1; m_oport[g] = w; m_owner[g] = w;
               end else if (rdy != 2'b00) begin
                  m_out[g] = 1'b0; m_last[g] = m_oport[g];
               end
               m_pend_prev[g] = cur;
            end
         end
      end
   endtask

   // Random-latency memory model used only while auto_resp is set.
   task automatic responder();
      int cnt [2];
      cnt[0] = 0; cnt[1] = 0;
      forever begin
         step();
         if (!rst_n) begin cnt[0] = 0; cnt[1] = 0; end
         if (auto_resp) begin
            for (int g = 0; g < 2; g++) begin
               mem_ready[g] = 1'b0;
               if (rst_n) begin
                  if (mm_rd[g] | mm_wr[g]) begin
                     cnt[g] = $urandom_range(1, 4);
                     if ($urandom_range(0, 3) == 0) begin
                        mem_ready[g] = 1'b1; mem_line[g] = rand_line();
                     end
                  end else if (cnt[g] > 0) begin
                     cnt[g]--;
                     if (cnt[g] == 0) begin
                        mem_ready[g] = 1'b1; mem_line[g] = rand_line();
                     end
                  end else if ($urandom_range(0, 15) == 0) begin
                     mem_ready[g] = 1'b1; mem_line[g] = rand_line();
                  end
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      step();
      rst_n = 1'b0;
      ptw_rd = 1; cc_rd = 1; ptw_addr = 32'h11; cc_addr = 32'h22;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if ({busy[g], owner[g], perr[g], mm_rd[g], mm_wr[g], ptw_ready[g], cc_ready[g]} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs[%0d]: busy=%b owner=%b perr=%b req=%b%b, required 0", g,
                     busy[g], owner[g], perr[g], mm_rd[g], mm_wr[g]);
         end
      end
      step();
      clear_inputs();
      rst_n = 1'b1;
      step();
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (busy[g] !== 1'b0 || owner[g] !== 1'b0 || perr[g] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release[%0d]: busy=%b owner=%b perr=%b, required 0 0 0", g, busy[g], owner[g], perr[g]);
         end
      end
   endtask

   task automatic test_single_read();
      logic [LINE_W-1:0] a5;
      a5 = {64{8'hA5}};
      do_reset();
      step(); cc_addr = 32'h0000_1040; cc_rd = 1;
      step(); cc_rd = 0;
      step();
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (mm_rd[g] !== 1'b1 || mm_wr[g] !== 1'b0 || mm_addr[g] !== 32'h0000_1040 || owner[g] !== 1'b1) begin
            errors++;
            $display("FAIL single_issue[%0d]: rd=%b wr=%b addr=%h owner=%b, required 1 0 00001040 1",
                     g, mm_rd[g], mm_wr[g], mm_addr[g], owner[g]);
         end
      end
      step(); step();
      step(); mem_ready = 2'b11; mem_line[0] = a5; mem_line[1] = a5;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (cc_ready[g] !== 1'b1 || cc_din[g] !== a5 || ptw_ready[g] !== 1'b0 || ptw_din[g] !== '0) begin
            errors++;
            $display("FAIL single_ready[%0d]: cc_ready=%b cc_din[31:0]=%h ptw_ready=%b, required 1 a5a5a5a5 0",
                     g, cc_ready[g], cc_din[g][31:0], ptw_ready[g]);
         end
      end
      step(); mem_ready = 2'b00;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (cc_ready[g] !== 1'b0 || cc_din[g] !== '0 || busy[g] !== 1'b0) begin
            errors++;
            $display("FAIL single_after[%0d]: cc_ready=%b busy=%b, required 0 0", g, cc_ready[g], busy[g]);
         end
      end
   endtask

   task automatic test_tie();
      do_reset();
      step();
      ptw_addr = 32'h2000; ptw_wdata = 32'hDEAD_BEEF; ptw_wr = 1;
      cc_addr = 32'h3000; cc_rd = 1;
      step(); clear_inputs();
      step();
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (mm_wr[g] !== 1'b1 || mm_rd[g] !== 1'b0 || mm_addr[g] !== 32'h2000 ||
             mm_wd[g] !== 32'hDEAD_BEEF || owner[g] !== 1'b0) begin
            errors++;
            $display("FAIL tie_first[%0d]: wr=%b addr=%h wd=%h owner=%b, required 1 00002000 deadbeef 0",
                     g, mm_wr[g], mm_addr[g], mm_wd[g], owner[g]);
         end
      end
      // ptw completes and re-requests in the same cycle
      step(); mem_ready = 2'b11; mem_line[0] = rand_line(); mem_line[1] = mem_line[0];
      ptw_rd = 1; ptw_addr = 32'h2400;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (ptw_ready[g] !== 1'b1 || cc_ready[g] !== 1'b0) begin
            errors++;
            $display("FAIL tie_ptw_ready[%0d]: ptw_ready=%b cc_ready=%b, required 1 0", g, ptw_ready[g], cc_ready[g]);
         end
      end
      step(); mem_ready = 2'b00; ptw_rd = 0;
      step();
      @(negedge clk);
      checks++;
      if (mm_rd[0] !== 1'b1 || mm_addr[0] !== 32'h3000 || owner[0] !== 1'b1) begin
         errors++;
         $display("FAIL tie_rr_second: rd=%b addr=%h owner=%b, required 1 00003000 1", mm_rd[0], mm_addr[0], owner[0]);
      end
      checks++;
      if (mm_rd[1] !== 1'b1 || mm_addr[1] !== 32'h2400 || owner[1] !== 1'b0) begin
         errors++;
         $display("FAIL tie_fp_second: rd=%b addr=%h owner=%b, required 1 00002400 0", mm_rd[1], mm_addr[1], owner[1]);
      end
      step(); mem_ready = 2'b11;
      @(negedge clk);
      checks++;
      if (cc_ready[0] !== 1'b1 || ptw_ready[1] !== 1'b1 || ptw_ready[0] !== 1'b0 || cc_ready[1] !== 1'b0) begin
         errors++;
         $display("FAIL tie_second_ready: rr cc/ptw=%b%b fp ptw/cc=%b%b, required 10 10",
                  cc_ready[0], ptw_ready[0], ptw_ready[1], cc_ready[1]);
      end
      step(); mem_ready = 2'b00;
      step();
      @(negedge clk);
      checks++;
      if (mm_addr[0] !== 32'h2400 || owner[0] !== 1'b0 || mm_addr[1] !== 32'h3000 || owner[1] !== 1'b1) begin
         errors++;
         $display("FAIL tie_third: rr addr=%h owner=%b fp addr=%h owner=%b, required 00002400 0 00003000 1",
                  mm_addr[0], owner[0], mm_addr[1], owner[1]);
      end
      step(); mem_ready = 2'b11;
      step(); mem_ready = 2'b00;
   endtask

   task automatic test_fixed_prio();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step();
         ptw_addr = 32'h4000 + 32'(k); ptw_rd = 1;
         cc_addr  = 32'h5000 + 32'(k); cc_rd  = 1;
         step(); clear_inputs();
         step();
         @(negedge clk);
         checks++;
         if (owner[1] !== 1'b0 || mm_rd[1] !== 1'b1 || mm_addr[1] !== 32'h4000 + 32'(k)) begin
            errors++;
            $display("FAIL fixed_first_%0d: owner=%b addr=%h, required 0 %h", k, owner[1], mm_addr[1], 32'h4000 + 32'(k));
         end
         step(); mem_ready = 2'b11;
         step(); mem_ready = 2'b00;
         step();
         @(negedge clk);
         checks++;
         if (owner[1] !== 1'b1 || mm_rd[1] !== 1'b1 || mm_addr[1] !== 32'h5000 + 32'(k)) begin
            errors++;
            $display("FAIL fixed_second_%0d: owner=%b addr=%h, required 1 %h", k, owner[1], mm_addr[1], 32'h5000 + 32'(k));
         end
         step(); mem_ready = 2'b11;
         step(); mem_ready = 2'b00;
      end
   endtask

   task automatic test_drop();
      int n_ready [2];
      do_reset();
      step(); cc_addr = 32'h5000; cc_rd = 1;
      step(); cc_addr = 32'h6000; cc_rd = 1;
      step(); cc_rd = 0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (perr[g] !== 1'b1 || mm_addr[g] !== 32'h5000) begin
            errors++;
            $display("FAIL drop_flag[%0d]: perr=%b addr=%h, required 1 00005000", g, perr[g], mm_addr[g]);
         end
         n_ready[g] = 0;
      end
      step(); mem_ready = 2'b11;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) if (cc_ready[g] === 1'b1) n_ready[g]++;
         step(); mem_ready = 2'b00;
      end
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (n_ready[g] != 1 || perr[g] !== 1'b1) begin
            errors++;
            $display("FAIL drop_once[%0d]: ready pulses=%0d perr=%b, required 1 1", g, n_ready[g], perr[g]);
         end
      end
   endtask

   task automatic test_both_pulse();
      bit seen [2];
      do_reset();
      step(); ptw_addr = 32'h7000; ptw_rd = 1; ptw_wr = 1;
      step(); clear_inputs();
      seen[0] = 0; seen[1] = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) if (mm_rd[g] | mm_wr[g] | busy[g]) seen[g] = 1;
         step();
      end
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (seen[g] || perr[g] !== 1'b1) begin
            errors++;
            $display("FAIL both_pulse[%0d]: memory activity=%0d perr=%b, required 0 1", g, seen[g], perr[g]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [LINE_W-1:0] l;
      do_reset();
      step(); ptw_addr = 32'h8000; ptw_rd = 1;
      step(); clear_inputs();
      step(); step(); step();
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (busy[g] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy[%0d]: busy=%b, required 1", g, busy[g]);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         checks++;
         if ({busy[g], owner[g], perr[g], mm_rd[g], mm_wr[g], ptw_ready[g], cc_ready[g]} !== 7'b0 ||
             mm_addr[g] !== '0) begin
            errors++;
            $display("FAIL rstmid_zero[%0d]: busy=%b owner=%b req=%b%b addr=%h, required 0", g,
                     busy[g], owner[g], mm_rd[g], mm_wr[g], mm_addr[g]);
         end
      end
      step(); step(); rst_n = 1'b1;
      step(); mem_ready = 2'b11; mem_line[0] = rand_line(); mem_line[1] = mem_line[0];
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (ptw_ready[g] !== 1'b0 || cc_ready[g] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale[%0d]: ptw_ready=%b cc_ready=%b, required 0 0", g, ptw_ready[g], cc_ready[g]);
         end
      end
      step(); mem_ready = 2'b00; ptw_addr = 32'h9000; ptw_rd = 1;
      step(); clear_inputs();
      step();
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (mm_rd[g] !== 1'b1 || mm_addr[g] !== 32'h9000) begin
            errors++;
            $display("FAIL rstmid_next_issue[%0d]: rd=%b addr=%h, required 1 00009000", g, mm_rd[g], mm_addr[g]);
         end
      end
      l = rand_line();
      step(); mem_ready = 2'b11; mem_line[0] = l; mem_line[1] = l;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (ptw_ready[g] !== 1'b1 || ptw_din[g] !== l) begin
            errors++;
            $display("FAIL rstmid_next_ready[%0d]: ptw_ready=%b din[31:0]=%h, required 1 %h",
                     g, ptw_ready[g], ptw_din[g][31:0], l[31:0]);
         end
      end
      step(); mem_ready = 2'b00;
   endtask

   task automatic test_random();
      do_reset();
      auto_resp = 1'b1;
      for (int c = 0; c < 800; c++) begin
         step();
         clear_inputs();
         if ($urandom_range(0, 2) == 0) begin
            ptw_addr = $urandom; ptw_wdata = $urandom;
            case ($urandom_range(0, 40))
               0:       begin ptw_rd = 1; ptw_wr = 1; end
               1, 2, 3: ptw_wr = 1;
               default: if ($urandom_range(0, 1) == 0) ptw_rd = 1; else ptw_wr = 1;
            endcase
         end
         if ($urandom_range(0, 2) == 0) begin
            cc_addr = $urandom; cc_wdata = $urandom;
            if ($urandom_range(0, 1) == 0) cc_rd = 1; else cc_wr = 1;
         end
      end
      step(); clear_inputs();
      repeat (40) step();
      auto_resp = 1'b0;
      mem_ready = 2'b00;
      step();
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (busy[g] !== 1'b0) begin
            errors++;
            $display("FAIL random_drain[%0d]: busy=%b, required 0", g, busy[g]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ptw_addr = '0; ptw_wdata = '0; cc_addr = '0; cc_wdata = '0;
      clear_inputs();
      mem_ready = 2'b00;
      mem_line[0] = '0; mem_line[1] = '0;
      fork
         monitor();
         responder();
      join_none
      step();
      step();
      rst_n = 1'b1;
      test_reset();
      test_single_read();
      test_tie();
      test_fixed_prio();
      test_drop();
      test_both_pulse();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/main_mem_arbiter.md
Name: main_mem_arbiter

Overview:
Shares the single main-memory port between two requesters: the MMU page-table walker (port 0, "ptw") and the cache controller miss/write-through path (port 1, "cc"). Each requester issues one-cycle read or write request pulses and waits for a one-cycle ready pulse. The arbiter latches each pulse, picks one request at a time (round-robin or fixed priority), and issues it to main memory. It routes the ready pulse and read line back only to the owning requester. It sits between the cache controller, the MMU and the main-memory model at the top level.

Parameters:
ADDR_W, 32, address width for both requesters and memory
DATA_W, 32, write-data width
LINE_W, 512, read-line width returned by memory
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 (ptw) always wins ties

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
ptw_addr  in  ADDR_W  port-0 address, sampled with the request pulse
ptw_wdata  in  DATA_W  port-0 write data
ptw_read_req  in  1  port-0 read pulse
ptw_write_req  in  1  port-0 write pulse
ptw_ready  out  1  port-0 completion pulse
ptw_data_in  out  LINE_W  port-0 read line, valid while ptw_ready=1
cc_addr  in  ADDR_W  port-1 address
cc_wdata  in  DATA_W  port-1 write data
cc_read_req  in  1  port-1 read pulse
cc_write_req  in  1  port-1 write pulse
cc_ready  out  1  port-1 completion pulse
cc_data_in  out  LINE_W  port-1 read line, valid while cc_ready=1
main_mem_addr  out  ADDR_W  memory address
main_mem_data_out  out  DATA_W  memory write data
main_mem_read_req  out  1  memory read pulse
main_mem_write_req  out  1  memory write pulse
main_mem_data_in  in  LINE_W  memory read line
main_mem_ready  in  1  memory completion pulse
arb_busy  out  1  high whenever the arbiter is not in IDLE
arb_owner  out  1  port index of the current or last grant
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 (arb_owner=0). Pending flags cleared. State IDLE. Round-robin pointer last_grant=1, so port 0 wins the first tie.
- Reset mid-transaction: the in-flight memory access is abandoned. No ready pulse is produced for it.
- Request capture, per port:
  - A read or write pulse at cycle T sets pend_valid at the T edge, stores addr, wdata and is_write.
  - A new pulse on a port whose pend_valid=1 is dropped and sets proto_err.
  - read_req and write_req both high in the same cycle is dropped and sets proto_err.
  - proto_err clears only on reset.
- State IDLE:
  - If any pend_valid is set, compute the grant, register arb_owner, go to ISSUE.
  - Round-robin: when both ports are pending, grant ~last_grant.
  - FIXED_PRIO=1: port 0 wins when both are pending.
  - A single pending port always wins.
- State ISSUE (exactly one cycle):
  - Drive main_mem_addr, main_mem_data_out and one of main_mem_read_req/main_mem_write_req from the owner's pending entry.
  - The req signal is high for this cycle only.
  - Go to WAIT.
  - main_mem_ready seen during ISSUE is ignored.
- State WAIT:
  - On main_mem_ready: the owner's ready output is 1 in the same cycle (combinational).
  - The owner's data_in equals main_mem_data_in in that cycle.
  - Clear the owner's pend_valid, set last_grant=owner, go to IDLE.
  - Ready for a write is returned the same way.
- When not in ISSUE, main_mem_addr, main_mem_data_out and the req signals are 0.
- Non-owner ready is always 0. Each requester's data_in is 0 unless that requester's ready is 1.
- Latency: request at T → memory request at T+2 → requester ready in the same cycle as main_mem_ready (earliest T+3).
- Back-to-back: the losing port is issued 2 cycles after the winner's ready. An IDLE cycle is always inserted between transactions.
- A new request from the owner in the same cycle as its ready is accepted, because pend_valid is cleared that edge.
- Any undefined state goes to IDLE.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding localparams: ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2;
  - port IDs: PORT_PTW=0, PORT_CC=1;
  - default widths.
- Sub-module mem_arb_req_latch (one instance per port) holds:
  - the pending entry (valid, addr, wdata, is_write) and its capture/clear logic;
  - per-port error detection.
- The top-level module holds the FSM, the grant logic and the output muxing.

Test Plan:
- cc_read_req pulse, cc_addr=0x0000_1040 at T → main_mem_read_req=1 with addr 0x0000_1040 at T+2. Memory ready at T+5 with line 0xA5.. → cc_ready=1 and cc_data_in=0xA5.. at T+5. ptw_ready stays 0.
- ptw_write_req (0x2000, 0xDEADBEEF) and cc_read_req (0x3000) in the same cycle, round-robin → ptw is issued first. After ptw_ready, cc is issued 2 cycles later. In a repeat tie, cc wins.
- FIXED_PRIO=1 with three consecutive simultaneous pulse pairs → ptw is granted each time before cc.
- Second cc_read_req while cc is pending → dropped, proto_err=1 and stays 1. The original request still completes once.
- read_req and write_req high together on ptw → no memory request, proto_err=1.
- rst_n asserted during WAIT → all outputs 0 immediately. A later main_mem_ready produces no requester ready. The next request is serviced normally.
